// File: rtl/seq_det_scheduler_if.sv
// Bus bundle for the serial pattern detector: config handshake, run control,
// bit stream and run results. The master drives config/stream, the slave is the detector.
interface seq_det_scheduler_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_max_hits;
  logic [TMO_W-1:0]   cfg_timeout;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               in;
  logic               in_valid;
  logic               hit;
  logic [CNT_W-1:0]   hit_count;
  logic               busy;
  logic               done;
  logic [1:0]         status;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_max_hits, cfg_timeout,
    output start, abort, in, in_valid,
    input  cfg_ready, cfg_err, hit, hit_count, busy, done, status
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_max_hits, cfg_timeout,
    input  start, abort, in, in_valid,
    output cfg_ready, cfg_err, hit, hit_count, busy, done, status
  );
endinterface

// File: rtl/seq_det_scheduler.sv
// Run-time serial pattern detector: programmable pattern/length/overlap, hit limit
// and bit timeout; registered hit/done pulses and a final status code per run.
module seq_det_scheduler #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, SCAN, DONE} state_t;

  localparam logic [3:0] MaxLenW = 4'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] cfgPattern_q, cfgPattern_d;
  logic [3:0]         cfgLen_q, cfgLen_d;
  logic               cfgOverlap_q, cfgOverlap_d;
  logic [CNT_W-1:0]   cfgMaxHits_q, cfgMaxHits_d;
  logic [TMO_W-1:0]   cfgTimeout_q, cfgTimeout_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [3:0]         fill_q, fill_d;
  logic [TMO_W-1:0]   bitCnt_q, bitCnt_d;
  logic [CNT_W-1:0]   hitCount_q, hitCount_d;
  logic [1:0]         status_q, status_d;
  logic               hit_q, hit_d;
  logic               done_q, done_d;
  logic               cfgErr_q, cfgErr_d;

  logic [MAX_LEN-1:0] newHist;
  logic [MAX_LEN-1:0] lenMask;
  logic [3:0]         newFill;
  logic [TMO_W-1:0]   newBitCnt;
  logic [CNT_W-1:0]   newHitCount;
  logic               isMatch;
  logic               cfgLegal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cfgPattern_q <= '0;
      cfgLen_q     <= '0;
      cfgOverlap_q <= 1'b0;
      cfgMaxHits_q <= '0;
      cfgTimeout_q <= '0;
      hist_q       <= '0;
      fill_q       <= '0;
      bitCnt_q     <= '0;
      hitCount_q   <= '0;
      status_q     <= '0;
      hit_q        <= 1'b0;
      done_q       <= 1'b0;
      cfgErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfgPattern_q <= cfgPattern_d;
      cfgLen_q     <= cfgLen_d;
      cfgOverlap_q <= cfgOverlap_d;
      cfgMaxHits_q <= cfgMaxHits_d;
      cfgTimeout_q <= cfgTimeout_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      bitCnt_q     <= bitCnt_d;
      hitCount_q   <= hitCount_d;
      status_q     <= status_d;
      hit_q        <= hit_d;
      done_q       <= done_d;
      cfgErr_q     <= cfgErr_d;
    end
  end

  // Match is judged on the history and fill count with the incoming bit included.
  always_comb begin
    newHist     = {hist_q[MAX_LEN-2:0], bus.in};
    newFill     = (fill_q == MaxLenW) ? fill_q : fill_q + 4'd1;
    newBitCnt   = bitCnt_q + 1'b1;
    newHitCount = (&hitCount_q) ? hitCount_q : hitCount_q + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      lenMask[i] = (i < int'(cfgLen_q));
    end
    isMatch  = (newFill >= cfgLen_q) && (((newHist ^ cfgPattern_q) & lenMask) == '0);
    cfgLegal = (bus.cfg_len != 4'd0) && (bus.cfg_len <= MaxLenW);
  end

  always_comb begin
    state_d      = state_q;
    cfgPattern_d = cfgPattern_q;
    cfgLen_d     = cfgLen_q;
    cfgOverlap_d = cfgOverlap_q;
    cfgMaxHits_d = cfgMaxHits_q;
    cfgTimeout_d = cfgTimeout_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    bitCnt_d     = bitCnt_q;
    hitCount_d   = hitCount_q;
    status_d     = status_q;
    hit_d        = 1'b0;
    done_d       = 1'b0;
    cfgErr_d     = 1'b0;

    case (state_q)
      IDLE, DONE, ARMED: begin
        if ((state_q != ARMED) && bus.cfg_valid) begin
          if (cfgLegal) begin
            cfgPattern_d = bus.cfg_pattern;
            cfgLen_d     = bus.cfg_len;
            cfgOverlap_d = bus.cfg_overlap;
            cfgMaxHits_d = bus.cfg_max_hits;
            cfgTimeout_d = bus.cfg_timeout;
            state_d      = ARMED;
          end else begin
            cfgErr_d = 1'b1;
          end
        end else if ((state_q != IDLE) && bus.start) begin
          hist_d     = '0;
          fill_d     = '0;
          bitCnt_d   = '0;
          hitCount_d = '0;
          status_d   = 2'b00;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          status_d = 2'b11;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (bus.in_valid) begin
          hist_d   = newHist;
          fill_d   = newFill;
          bitCnt_d = newBitCnt;
          if (isMatch) begin
            hit_d      = 1'b1;
            hitCount_d = newHitCount;
            fill_d     = cfgOverlap_q ? newFill : 4'd0;
          end
          if (isMatch && (cfgMaxHits_q != '0) && (newHitCount == cfgMaxHits_q)) begin
            status_d = 2'b01;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if ((cfgTimeout_q != '0) && (newBitCnt == cfgTimeout_q)) begin
            status_d = 2'b10;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign bus.cfg_err   = cfgErr_q;
  assign bus.hit       = hit_q;
  assign bus.hit_count = hitCount_q;
  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = done_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler: hand-computed hit/done/status expectations
// for the configured runs, with immediate assertions at every comparison.
module tb_seq_det_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_det_scheduler_if #(.MAX_LEN(8), .CNT_W(8), .TMO_W(16)) bus ();

  seq_det_scheduler #(.MAX_LEN(8), .CNT_W(8), .TMO_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one stream bit for one clock; outputs are then sampled 1ns after the edge.
  task automatic applyStimulus(input logic b, input logic v);
    bus.in       = b;
    bus.in_valid = v;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in       = 1'b0;
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n,
                          output logic [15:0] hitMask, output logic [15:0] doneMask);
    hitMask  = '0;
    doneMask = '0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(bits[n-1-i], 1'b1);
      hitMask[i]  = bus.hit;
      doneMask[i] = bus.done;
    end
  endtask

  task automatic doConfig(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic [7:0] lim, input logic [15:0] tmo);
    bus.cfg_pattern  = pat;
    bus.cfg_len      = len;
    bus.cfg_overlap  = ovl;
    bus.cfg_max_hits = lim;
    bus.cfg_timeout  = tmo;
    bus.cfg_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [15:0] hitMask;
  logic [15:0] doneMask;
  int          hitPulses;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
    bus.cfg_max_hits = '0; bus.cfg_timeout = '0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.in = 1'b0; bus.in_valid = 1'b0;

    doReset();
    checkOutput("reset_hit", bus.hit, 0);
    checkOutput("reset_hit_count", bus.hit_count, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_status", bus.status, 0);
    checkOutput("reset_cfg_err", bus.cfg_err, 0);
    checkOutput("reset_cfg_ready", bus.cfg_ready, 1);

    // Test 1: non-overlap, timeout 9, stream 100010001.
    doConfig(8'b10001, 4'd5, 1'b0, 8'd0, 16'd9);
    checkOutput("t1_armed_cfg_ready", bus.cfg_ready, 0);
    pulseStart();
    checkOutput("t1_busy", bus.busy, 1);
    sendBits(16'b100010001, 9, hitMask, doneMask);
    checkOutput("t1_hit_mask", hitMask, 16'h0010);
    checkOutput("t1_done_mask", doneMask, 16'h0100);
    checkOutput("t1_status", bus.status, 2'b10);
    checkOutput("t1_hit_count", bus.hit_count, 1);
    checkOutput("t1_busy_after", bus.busy, 0);
    checkOutput("t1_done_ready", bus.cfg_ready, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_done_pulse_end", bus.done, 0);

    // Test 2: overlap mode from DONE, with an idle gap that must not advance anything.
    doConfig(8'b10001, 4'd5, 1'b1, 8'd0, 16'd9);
    pulseStart();
    checkOutput("t2_status_cleared", bus.status, 0);
    checkOutput("t2_count_cleared", bus.hit_count, 0);
    sendBits(16'b1000, 4, hitMask, doneMask);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    sendBits(16'b10001, 5, hitMask, doneMask);
    checkOutput("t2_hit_mask", hitMask, 16'h0011);
    checkOutput("t2_done_mask", doneMask, 16'h0010);
    checkOutput("t2_status", bus.status, 2'b10);
    checkOutput("t2_hit_count", bus.hit_count, 2);

    // Test 3: illegal lengths from IDLE.
    doReset();
    doConfig(8'b10001, 4'd0, 1'b0, 8'd0, 16'd9);
    checkOutput("t3_cfg_err_len0", bus.cfg_err, 1);
    checkOutput("t3_still_idle_ready", bus.cfg_ready, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_cfg_err_pulse_end", bus.cfg_err, 0);
    doConfig(8'b10001, 4'd9, 1'b0, 8'd0, 16'd9);
    checkOutput("t3_cfg_err_len9", bus.cfg_err, 1);
    pulseStart();
    checkOutput("t3_start_ignored", bus.busy, 0);

    // Test 4: limit 1 and timeout 5 coincide; hit limit has priority.
    doConfig(8'b10001, 4'd5, 1'b0, 8'd1, 16'd5);
    checkOutput("t4_cfg_err_clear", bus.cfg_err, 0);
    pulseStart();
    sendBits(16'b10001, 5, hitMask, doneMask);
    checkOutput("t4_hit", bus.hit, 1);
    checkOutput("t4_done", bus.done, 1);
    checkOutput("t4_status", bus.status, 2'b01);
    checkOutput("t4_hit_count", bus.hit_count, 1);

    // Test 5: abort after bit 3; a valid bit in the abort cycle is dropped.
    doConfig(8'b10001, 4'd5, 1'b0, 8'd0, 16'd0);
    pulseStart();
    sendBits(16'b100, 3, hitMask, doneMask);
    bus.abort = 1'b1;
    applyStimulus(1'b0, 1'b1);
    bus.abort = 1'b0;
    checkOutput("t5_done", bus.done, 1);
    checkOutput("t5_status", bus.status, 2'b11);
    checkOutput("t5_hit_count", bus.hit_count, 0);
    checkOutput("t5_hit", bus.hit, 0);
    // Re-run from DONE with the held config.
    pulseStart();
    checkOutput("t5_rerun_status", bus.status, 0);
    sendBits(16'b10001, 5, hitMask, doneMask);
    checkOutput("t5_rerun_hit_mask", hitMask, 16'h0010);
    checkOutput("t5_rerun_busy", bus.busy, 1);

    // Test 6: reset mid-scan.
    sendBits(16'b11, 2, hitMask, doneMask);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6_busy", bus.busy, 0);
    checkOutput("t6_hit_count", bus.hit_count, 0);
    checkOutput("t6_status", bus.status, 0);
    checkOutput("t6_done", bus.done, 0);
    rst = 1'b1;
    pulseStart();
    checkOutput("t6_start_ignored", bus.busy, 0);

    // hit_count saturation: 1-bit pattern, overlap, 260 ones.
    doConfig(8'b1, 4'd1, 1'b1, 8'd0, 16'd0);
    pulseStart();
    hitPulses = 0;
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (bus.hit) hitPulses++;
    end
    checkOutput("sat_hit_count", bus.hit_count, 8'hFF);
    checkOutput("sat_hit_pulses", hitPulses, 260);
    bus.abort = 1'b1;
    applyStimulus(1'b0, 1'b0);
    bus.abort = 1'b0;
    checkOutput("sat_abort_status", bus.status, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
